fib_bcd_converter: RTL and testbench
====================================

FIB_BCD_CONVERTER -- requirements
Module: fib_bcd_converter

Interface
REQ-001 Parameter IN_W, default 20, binary input width; SHALL match the 20-bit Fibonacci output of the upstream generator.
REQ-002 Parameter DIGITS, default 7, number of BCD output digits; SHALL satisfy 10^DIGITS > 2^IN_W.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream offers in_data.
REQ-006 in_data  input  IN_W  unsigned binary value to convert (Fibonacci number).
REQ-007 in_ready  output  1  block accepts in_data; transfer occurs on an edge where in_valid && in_ready.
REQ-008 out_valid  output  1  out_bcd holds a completed result.
REQ-009 out_ready  input  1  downstream consumes the result; transfer occurs on an edge where out_valid && out_ready.
REQ-010 out_bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE only.
REQ-013 IDLE: in_ready=1; on an in_valid edge, capture in_data, clear the BCD accumulator, load the iteration counter with IN_W, and go to SHIFT.
REQ-014 SHIFT: each edge, add 3 to every accumulator digit >= 5, then shift {accumulator, binary} left by one bit (double dabble); decrement the counter.
REQ-015 SHIFT SHALL last exactly IN_W edges; the edge performing the final shift loads out_bcd and enters DONE.
REQ-016 Latency: out_valid SHALL rise exactly IN_W cycles after the accepting edge (20 cycles at default).
REQ-017 DONE: out_valid=1; out_bcd and out_valid SHALL remain stable while out_ready=0.
REQ-018 DONE with out_ready=1: return to IDLE on that edge; out_valid falls in the next cycle.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; in_valid is ignored there. There is no back-to-back accept in the DONE->IDLE cycle, so minimum spacing between accepts is IN_W+2 cycles.
REQ-020 out_bcd SHALL retain the last result after the handshake until the next entry to DONE.
REQ-021 Every out_bcd digit SHALL be in 0..9; the accumulator SHALL never overflow for any in_data in 0..2^IN_W-1.
REQ-022 in_data=0 SHALL yield out_bcd=0 with the same latency as any other value (no early exit).

Reset
REQ-023 While reset is high: state=IDLE, out_valid=0, out_bcd=0, accumulator, counter and captured binary = 0, busy=0.
REQ-024 in_ready SHALL be 0 while reset is high and 1 from the first cycle after release.
REQ-025 Reset mid-SHIFT or mid-DONE SHALL abort the operation with no out_valid pulse; the partial result is discarded.

Configuration
REQ-026 Macro FIB_BCD_DIGIT_COUNT_EN, when defined, SHALL add output out_ndigits (width 3 at default, ceil(log2(DIGITS+1)) in general), registered with out_bcd.
REQ-027 out_ndigits SHALL equal the index of the most significant non-zero digit plus 1, and 1 for a zero result; it SHALL be 0 during reset and stable with out_bcd.
REQ-028 Without the macro, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Release reset, in_data=0 -> out_valid exactly 20 cycles after accept; out_bcd=0x0000000; out_ndigits=1 (macro on).
REQ-030 in_data=6765 (F20) -> out_bcd=0x0006765, out_ndigits=4; in_ready=0 and busy=1 for the entire conversion.
REQ-031 in_data=0xFFFFF -> out_bcd=0x1048575, out_ndigits=7.
REQ-032 in_data=832040 (F30), out_ready held 0 for 5 cycles in DONE -> out_bcd=0x0832040 stable throughout; in_valid pulses ignored; IDLE one cycle after out_ready=1.
REQ-033 Reset pulsed 10 cycles into a conversion of 4181 -> no out_valid; next accept of 75025 -> out_bcd=0x0075025 after 20 cycles.
REQ-034 Back-to-back requests with in_valid held high and out_ready=1 -> accepts spaced exactly 22 cycles apart; each result correct.

Source files
------------

// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle for fib_bcd_converter: binary request side and BCD result side.
// out_ndigits exists only when FIB_BCD_DIGIT_COUNT_EN is defined.
interface fib_bcd_converter_if #(
  parameter int IN_W   = 20,
  parameter int DIGITS = 7
);
  localparam int ND_W = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic [IN_W-1:0]       in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
`ifdef FIB_BCD_DIGIT_COUNT_EN
  logic [ND_W-1:0]       out_ndigits;
`endif

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
`ifdef FIB_BCD_DIGIT_COUNT_EN
    input  out_ndigits,
`endif
    input  out_bcd
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
`ifdef FIB_BCD_DIGIT_COUNT_EN
    output out_ndigits,
`endif
    output out_bcd
  );
endinterface

// File: rtl/fib_bcd_converter.sv
// Double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Defining FIB_BCD_DIGIT_COUNT_EN adds out_ndigits (count of significant decimal digits).
module fib_bcd_converter #(
  parameter int IN_W   = 20,
  parameter int DIGITS = 7
) (
  input  logic               clock,
  input  logic               reset,
  fib_bcd_converter_if.slave bus,
  output logic               busy_o
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
`ifdef FIB_BCD_DIGIT_COUNT_EN
  localparam int ND_W  = $clog2(DIGITS + 1);
`endif

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // SHIFT | IN_W add-3/shift steps, no early exit
  // DONE  | result presented until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_d;
  logic [IN_W-1:0]  bin_q;
  logic [IN_W-1:0]  bin_d;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] out_bcd_q;
  logic             out_valid_q;

  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj[BCD_W-2:0], bin_q[IN_W-1]};
    bin_d = {bin_q[IN_W-2:0], 1'b0};
  end

`ifdef FIB_BCD_DIGIT_COUNT_EN
  logic [ND_W-1:0] nd_d;
  logic [ND_W-1:0] nd_q;

  // Highest non-zero digit wins; a zero result still reports one digit.
  always_comb begin
    nd_d = ND_W'(1);
    for (int k = 1; k < DIGITS; k++) begin
      if (acc_d[4*k +: 4] != 4'd0) begin
        nd_d = ND_W'(k + 1);
      end
    end
  end

  assign bus.out_ndigits = nd_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef FIB_BCD_DIGIT_COUNT_EN
      nd_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q   <= bus.in_data;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(IN_W);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            out_bcd_q   <= acc_d;
            out_valid_q <= 1'b1;
`ifdef FIB_BCD_DIGIT_COUNT_EN
            nd_q        <= nd_d;
`endif
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is gated by reset so it reads 0 while reset is asserted.
  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = out_bcd_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_fib_bcd_converter.sv
// Self-checking bench for fib_bcd_converter against a decimal-arithmetic reference model.
module tb_fib_bcd_converter;
  logic clock;
  logic reset;
  logic busy;
  int   n_assert;
  int   n_fail;

  fib_bcd_converter_if #(.IN_W(20), .DIGITS(7)) bus ();

  fib_bcd_converter #(.IN_W(20), .DIGITS(7)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .busy_o (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [27:0] ref_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 7; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int ref_ndigits(input int unsigned v);
    int n;
    int unsigned x;
    n = 1;
    x = v / 10;
    while (x > 0) begin
      n++;
      x = x / 10;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input int unsigned v);
    check({tag, " out_bcd"}, 64'(bus.out_bcd), 64'(ref_bcd(v)));
`ifdef FIB_BCD_DIGIT_COUNT_EN
    check({tag, " ndigits"}, 64'(bus.out_ndigits), 64'(ref_ndigits(v)));
`endif
  endtask

  // One full transaction: accept, measure latency, hold in DONE for 'hold' cycles, then drain.
  task automatic run_conv(input int unsigned v, input int hold, input string tag);
    int cyc;
    int bad;
    @(negedge clock);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 20'(v);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 20'($urandom);
    cyc = 0;
    bad = 0;
    while (cyc < 40) begin
      @(negedge clock);
      if (bus.out_valid) break;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
      bus.in_valid = 1'($urandom);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd20);
    check({tag, " busy/ready during shift"}, 64'(bad), 64'd0);
    check_result(tag, v);
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom);
      @(posedge clock);
      @(negedge clock);
      check({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
      check_result({tag, " hold"}, v);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    check({tag, " drained out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " drained busy"}, 64'(busy), 64'd0);
    check({tag, " drained in_ready"}, 64'(bus.in_ready), 64'd1);
    check_result({tag, " retained"}, v);
  endtask

  initial begin
    int unsigned vals[4];
    int unsigned q[$];
    int cycle;
    int last;
    int nacc;
    int nres;
    int seen;
    logic acc_now;

    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clock);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_bcd", 64'(bus.out_bcd), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd0);
`ifdef FIB_BCD_DIGIT_COUNT_EN
    check("rst ndigits", 64'(bus.out_ndigits), 64'd0);
`endif
    reset = 1'b0;
    #1;
    check("release in_ready", 64'(bus.in_ready), 64'd1);

    run_conv(0, 0, "zero");
    run_conv(6765, 0, "f20");
    run_conv(20'hFFFFF, 1, "max");
    run_conv(832040, 5, "f30");

    // Abort a conversion of 4181 ten cycles in.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 20'd4181;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort out_bcd", 64'(bus.out_bcd), 64'd0);
    check("abort in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.out_valid) seen++;
    end
    check("abort no out_valid", 64'(seen), 64'd0);
    run_conv(75025, 0, "f25");

    for (int i = 0; i < 4; i++) begin
      run_conv($urandom_range(0, 20'hFFFFF), int'($urandom_range(0, 3)), "rand");
    end

    // Back-to-back: in_valid held high, out_ready high.
    for (int i = 0; i < 4; i++) vals[i] = $urandom_range(0, 20'hFFFFF);
    cycle = 0;
    last  = -1;
    nacc  = 0;
    nres  = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'(vals[0]);
    while (nres < 4 && cycle < 300) begin
      @(negedge clock);
      acc_now = 1'b0;
      if (bus.out_valid) begin
        if (q.size() > 0) check_result("b2b", q.pop_front());
        nres++;
      end
      if (bus.in_ready && bus.in_valid) begin
        acc_now = 1'b1;
        if (last >= 0) check("b2b spacing", 64'(cycle - last), 64'd22);
        last = cycle;
        q.push_back(vals[nacc]);
        nacc++;
      end
      @(posedge clock);
      cycle++;
      #1;
      if (acc_now) begin
        if (nacc < 4) bus.in_data = 20'(vals[nacc]);
        else bus.in_valid = 1'b0;
      end
    end
    check("b2b results", 64'(nres), 64'd4);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
